// File: rtl/alu_flag_branch.sv
// Flag register and conditional-branch resolver at the ALU result interface.
// Optional macro FLAG_FWD_EN: forward same-cycle flag writes into branch evaluation instead of stalling.
module alu_flag_branch #(
    parameter int PC_W  = 16,
    parameter int OFF_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [2:0]       alu_opcode,
    input  logic             Z_in,
    input  logic             OV_in,
    input  logic             N_in,
    input  logic             br_valid,
    input  logic [2:0]       br_cond,
    input  logic [PC_W-1:0]  br_pc_plus1,
    input  logic [OFF_W-1:0] br_offset,
    input  logic             kill,
    output logic [2:0]       flags,
    output logic             stall,
    output logic             br_done,
    output logic             br_taken,
    output logic [PC_W-1:0]  br_target,
    output logic             flush
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            state_r, state_s;
    logic [2:0]        flags_r, flags_s, eval_flags_s;
    logic              flag_wr_s, arith_s, hazard_s;
    logic              fire_s, stall_s, taken_s;
    logic [PC_W-1:0]   sext_off_s, target_s;
    logic              br_done_r, br_taken_r, flush_r;
    logic [PC_W-1:0]   br_target_r;

    // Flags are packed {Z, OV, N}
    function automatic logic cond_met(input logic [2:0] cond, input logic [2:0] f);
        logic z, ov, n;
        z  = f[2];
        ov = f[1];
        n  = f[0];
        case (cond)
            3'b000:  cond_met = ~z;
            3'b001:  cond_met = z;
            3'b010:  cond_met = ~z & ~n;
            3'b011:  cond_met = n;
            3'b100:  cond_met = z | (~z & ~n);
            3'b101:  cond_met = n | z;
            3'b110:  cond_met = ov;
            3'b111:  cond_met = 1'b1;
            default: cond_met = 1'b0;
        endcase
    endfunction

    assign flag_wr_s = (alu_opcode != 3'b110) && (alu_opcode != 3'b111);
    assign arith_s   = (alu_opcode == 3'b000) || (alu_opcode == 3'b001);
    assign hazard_s  = br_valid && alu_valid && flag_wr_s;

    // Next flag value: logic/shift ops keep OV, load-immediates write nothing
    always_comb begin
        flags_s = flags_r;
        if (alu_valid && flag_wr_s) begin
            flags_s[2] = Z_in;
            flags_s[0] = N_in;
            if (arith_s) begin
                flags_s[1] = OV_in;
            end else begin
                flags_s[1] = flags_r[1];
            end
        end else begin
            flags_s = flags_r;
        end
    end

    // Branch FSM: accept, stall on a flag hazard, or resolve a held branch
    always_comb begin
        state_s      = state_r;
        fire_s       = 1'b0;
        stall_s      = 1'b0;
        eval_flags_s = flags_r;
        case (state_r)
            ST_IDLE: begin
                if (kill) begin
                    state_s = ST_IDLE;
                end else if (br_valid) begin
`ifdef FLAG_FWD_EN
                    eval_flags_s = hazard_s ? flags_s : flags_r;
                    fire_s       = 1'b1;
`else
                    if (hazard_s) begin
                        stall_s = 1'b1;
                        state_s = ST_WAIT;
                    end else begin
                        fire_s = 1'b1;
                    end
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // The branch is held upstream; flags_r now holds the producer's result
                if (kill) begin
                    state_s = ST_IDLE;
                end else begin
                    fire_s  = 1'b1;
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign sext_off_s = {{(PC_W-OFF_W){br_offset[OFF_W-1]}}, br_offset};
    assign taken_s    = cond_met(br_cond, eval_flags_s);
    assign target_s   = taken_s ? (br_pc_plus1 + sext_off_s) : br_pc_plus1;

    // State, flag register and registered branch decision
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            flags_r     <= 3'b000;
            br_done_r   <= 1'b0;
            br_taken_r  <= 1'b0;
            flush_r     <= 1'b0;
            br_target_r <= {PC_W{1'b0}};
        end else begin
            state_r    <= state_s;
            flags_r    <= flags_s;
            br_done_r  <= fire_s;
            br_taken_r <= fire_s & taken_s;
            flush_r    <= fire_s & taken_s;
            if (fire_s) begin
                br_target_r <= target_s;
            end else begin
                br_target_r <= br_target_r;
            end
        end
    end

    assign flags     = flags_r;
    assign stall     = stall_s;
    assign br_done   = br_done_r;
    assign br_taken  = br_taken_r;
    assign br_target = br_target_r;
    assign flush     = flush_r;

endmodule

// File: tb/tb_alu_flag_branch.sv
// Directed self-checking bench for alu_flag_branch; adapts to FLAG_FWD_EN.
module tb_alu_flag_branch;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [2:0]  alu_opcode;
    logic        Z_in, OV_in, N_in;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic [15:0] br_pc_plus1;
    logic [8:0]  br_offset;
    logic        kill;
    logic [2:0]  flags;
    logic        stall, br_done, br_taken, flush;
    logic [15:0] br_target;

    int n_cmp = 0;
    int n_err = 0;

    alu_flag_branch #(.PC_W(16), .OFF_W(9)) dut (
        .clk(clk), .rst(rst), .alu_valid(alu_valid), .alu_opcode(alu_opcode),
        .Z_in(Z_in), .OV_in(OV_in), .N_in(N_in), .br_valid(br_valid), .br_cond(br_cond),
        .br_pc_plus1(br_pc_plus1), .br_offset(br_offset), .kill(kill), .flags(flags),
        .stall(stall), .br_done(br_done), .br_taken(br_taken), .br_target(br_target),
        .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic alu(input logic [2:0] op, input logic z, input logic ov, input logic n);
        alu_valid = 1'b1; alu_opcode = op; Z_in = z; OV_in = ov; N_in = n;
    endtask

    task automatic br(input logic [2:0] c, input logic [15:0] pc, input logic [8:0] off);
        br_valid = 1'b1; br_cond = c; br_pc_plus1 = pc; br_offset = off;
    endtask

    // Present all eight conditions back-to-back against fixed flags
    task automatic run_conds(input string tag, input logic [7:0] exp_tab);
        logic t;
        for (int c = 0; c < 8; c++) begin
            br(c[2:0], 16'h0100, 9'h005);
            tick;
            t = exp_tab[c];
            chk({tag, "_done"}, {31'd0, br_done}, 32'd1);
            chk({tag, "_taken"}, {31'd0, br_taken}, {31'd0, t});
            chk({tag, "_flush"}, {31'd0, flush}, {31'd0, t});
            chk({tag, "_target"}, {16'd0, br_target}, t ? 32'h0105 : 32'h0100);
        end
        br_valid = 1'b0;
        tick;
        chk({tag, "_idle"}, {31'd0, br_done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; alu_valid = 1'b0; alu_opcode = 3'b000; Z_in = 1'b0; OV_in = 1'b0; N_in = 1'b0;
        br_valid = 1'b0; br_cond = 3'b000; br_pc_plus1 = 16'h0000; br_offset = 9'h000; kill = 1'b0;
        tick; tick;
        chk("rst_flags", {29'd0, flags}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_done", {31'd0, br_done}, 32'd0);
        chk("rst_taken", {31'd0, br_taken}, 32'd0);
        chk("rst_target", {16'd0, br_target}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        rst = 1'b0;

        // Flag update rules
        alu(3'b000, 1'b1, 1'b1, 1'b0); tick;
        chk("add_flags", {29'd0, flags}, 32'b110);
        alu(3'b010, 1'b0, 1'b0, 1'b1); tick;
        chk("xor_flags", {29'd0, flags}, 32'b011);
        alu(3'b110, 1'b1, 1'b0, 1'b0); tick;
        chk("ll_flags", {29'd0, flags}, 32'b011);
        alu(3'b111, 1'b1, 1'b1, 1'b0); tick;
        chk("lh_flags", {29'd0, flags}, 32'b011);
        alu_valid = 1'b0; Z_in = 1'b1; tick;
        chk("noval_flags", {29'd0, flags}, 32'b011);

        // Conditions against flags 011 (Z=0 OV=1 N=1)
        run_conds("c011", 8'b1110_1001);

        // Z=1: EQ taken with negative offset, then NE not taken
        alu(3'b000, 1'b1, 1'b0, 1'b0); tick;
        alu_valid = 1'b0;
        chk("z_flags", {29'd0, flags}, 32'b100);
        br(3'b001, 16'h0010, 9'h1FD); #1;
        chk("eq_stall", {31'd0, stall}, 32'd0);
        tick;
        chk("eq_done", {31'd0, br_done}, 32'd1);
        chk("eq_taken", {31'd0, br_taken}, 32'd1);
        chk("eq_target", {16'd0, br_target}, 32'h000D);
        chk("eq_flush", {31'd0, flush}, 32'd1);
        br(3'b000, 16'h0010, 9'h1FD); tick;
        chk("ne_done", {31'd0, br_done}, 32'd1);
        chk("ne_taken", {31'd0, br_taken}, 32'd0);
        chk("ne_target", {16'd0, br_target}, 32'h0010);
        chk("ne_flush", {31'd0, flush}, 32'd0);
        br_valid = 1'b0; tick;
        chk("ne_idle", {31'd0, br_done}, 32'd0);

        // Conditions against flags 100 and 000
        run_conds("c100", 8'b1011_0010);
        alu(3'b000, 1'b0, 1'b0, 1'b0); tick;
        alu_valid = 1'b0;
        run_conds("c000", 8'b1001_0101);

        // Hazard: sub writes N=1 while LT is presented
        alu(3'b001, 1'b0, 1'b0, 1'b1);
        br(3'b011, 16'h0020, 9'h002); #1;
`ifdef FLAG_FWD_EN
        chk("hz_stall", {31'd0, stall}, 32'd0);
        tick;
        alu_valid = 1'b0; br_valid = 1'b0;
        chk("hz_done", {31'd0, br_done}, 32'd1);
        chk("hz_taken", {31'd0, br_taken}, 32'd1);
        chk("hz_target", {16'd0, br_target}, 32'h0022);
        chk("hz_flags", {29'd0, flags}, 32'b001);
        tick;
        chk("hz_idle", {31'd0, br_done}, 32'd0);
`else
        chk("hz_stall", {31'd0, stall}, 32'd1);
        tick;
        alu_valid = 1'b0; #1;
        chk("hz_wait_done", {31'd0, br_done}, 32'd0);
        chk("hz_flags", {29'd0, flags}, 32'b001);
        chk("hz_wait_stall", {31'd0, stall}, 32'd0);
        tick;
        br_valid = 1'b0;
        chk("hz_done", {31'd0, br_done}, 32'd1);
        chk("hz_taken", {31'd0, br_taken}, 32'd1);
        chk("hz_target", {16'd0, br_target}, 32'h0022);
        chk("hz_flush", {31'd0, flush}, 32'd1);
        tick;
        chk("hz_idle", {31'd0, br_done}, 32'd0);
`endif

        // Wrap and back-to-back ALWAYS branches
        br(3'b111, 16'hFFFF, 9'h001); tick;
        chk("b2b1_done", {31'd0, br_done}, 32'd1);
        chk("b2b1_target", {16'd0, br_target}, 32'h0000);
        br(3'b111, 16'h1234, 9'h1FF); tick;
        chk("b2b2_done", {31'd0, br_done}, 32'd1);
        chk("b2b2_target", {16'd0, br_target}, 32'h1233);
        br(3'b111, 16'h0000, 9'h100); tick;
        chk("b2b3_done", {31'd0, br_done}, 32'd1);
        chk("b2b3_target", {16'd0, br_target}, 32'hFF00);
        br_valid = 1'b0; tick;
        chk("b2b_idle", {31'd0, br_done}, 32'd0);

        // kill squashes the branch, flag update still happens
`ifdef FLAG_FWD_EN
        alu(3'b000, 1'b0, 1'b1, 1'b0);
        br(3'b111, 16'h0040, 9'h004);
        kill = 1'b1; tick;
        kill = 1'b0; alu_valid = 1'b0; br_valid = 1'b0;
        chk("kill_done", {31'd0, br_done}, 32'd0);
        chk("kill_flush", {31'd0, flush}, 32'd0);
        chk("kill_flags", {29'd0, flags}, 32'b010);
        tick;
        chk("kill_idle", {31'd0, br_done}, 32'd0);
        br(3'b111, 16'h0040, 9'h004);
        rst = 1'b1; tick;
        rst = 1'b0; br_valid = 1'b0;
        chk("rstw_done", {31'd0, br_done}, 32'd0);
        chk("rstw_flags", {29'd0, flags}, 32'd0);
        tick;
        chk("rstw_idle", {31'd0, br_done}, 32'd0);
`else
        alu(3'b001, 1'b1, 1'b0, 1'b0);
        br(3'b001, 16'h0040, 9'h004); tick;
        chk("kill_pre_flags", {29'd0, flags}, 32'b100);
        alu(3'b000, 1'b0, 1'b1, 1'b0);
        kill = 1'b1; tick;
        kill = 1'b0; alu_valid = 1'b0; br_valid = 1'b0;
        chk("kill_done", {31'd0, br_done}, 32'd0);
        chk("kill_flush", {31'd0, flush}, 32'd0);
        chk("kill_flags", {29'd0, flags}, 32'b010);
        tick;
        chk("kill_idle", {31'd0, br_done}, 32'd0);
        alu(3'b000, 1'b1, 1'b0, 1'b0);
        br(3'b111, 16'h0040, 9'h004); tick;
        alu_valid = 1'b0;
        rst = 1'b1; tick;
        rst = 1'b0; br_valid = 1'b0;
        chk("rstw_done", {31'd0, br_done}, 32'd0);
        chk("rstw_flags", {29'd0, flags}, 32'd0);
        tick;
        chk("rstw_idle", {31'd0, br_done}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
